// File: rtl/gate_sequencer.sv
// Power-gate sequencer: enables N gates one at a time, disables them in reverse,
// waits for the sync feedback to echo each pattern and faults on a sync timeout.
module gate_sequencer #(
  parameter int N_GATES = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [CNT_W-1:0]   shift_i,
  input  logic [N_GATES-1:0] gate_sync_i,
  output logic [N_GATES-1:0] gate_en_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic               fault_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DOWN,
    S_FAULT
  } state_t;

  localparam logic             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [N_GATES-1:0] gate_en_q, gate_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  logic               match;
  logic               run_step;
  logic               run_miss;
  logic [N_GATES-1:0] stepped;

  assign match = (gate_sync_i == gate_en_q);

  // Down-steps drop the most recently enabled gate first.
  assign stepped = (state_q == S_RAMP_DOWN) ? {1'b0, gate_en_q[N_GATES-1:1]}
                                            : {gate_en_q[N_GATES-2:0], 1'b1};

  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    shift_d   = shift_q;
    run_step  = 1'b0;
    run_miss  = 1'b0;

    case (state_q)
      S_IDLE: begin
        gate_en_d = '0;
        if (start_i && !stop_i) begin
          state_d  = S_RAMP_UP;
          shift_d  = shift_i;
          cnt_d    = '0;
          to_cnt_d = '0;
        end
      end
      S_RAMP_UP: begin
        if (stop_i) begin
          state_d  = S_RAMP_DOWN;
          shift_d  = shift_i;
          cnt_d    = '0;
          to_cnt_d = '0;
        end else if (match && (&gate_en_q)) begin
          state_d  = S_ON;
          cnt_d    = '0;
          to_cnt_d = '0;
        end else begin
          run_step = 1'b1;
        end
      end
      S_ON: begin
        if (stop_i) begin
          state_d  = S_RAMP_DOWN;
          shift_d  = shift_i;
          cnt_d    = '0;
          to_cnt_d = '0;
        end else if (match) begin
          to_cnt_d = '0;
        end else begin
          run_miss = 1'b1;
        end
      end
      S_RAMP_DOWN: begin
        if (start_i && !stop_i) begin
          state_d  = S_RAMP_UP;
          shift_d  = shift_i;
          cnt_d    = '0;
          to_cnt_d = '0;
        end else if (match && (gate_en_q == '0)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          to_cnt_d = '0;
        end else begin
          run_step = 1'b1;
        end
      end
      S_FAULT: begin
        gate_en_d = '0;
        if (stop_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          to_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        gate_en_d = '0;
        cnt_d     = '0;
        to_cnt_d  = '0;
      end
    endcase

    // Dwell counts matched cycles only; a mismatch stalls the step.
    if (run_step) begin
      if (match) begin
        to_cnt_d = '0;
        if (cnt_q == shift_q) begin
          gate_en_d = stepped;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        run_miss = 1'b1;
      end
    end

    if (run_miss) begin
      if (TO_EN && (to_cnt_q == TO_LAST)) begin
        state_d   = S_FAULT;
        gate_en_d = '0;
        cnt_d     = '0;
        to_cnt_d  = '0;
      end else if (TO_EN) begin
        to_cnt_d = to_cnt_q + CNT_ONE;
      end
    end

    busy_d  = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
    ready_d = (state_d == S_ON);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      gate_en_q <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign gate_en_o = gate_en_q;
  assign busy_o    = busy_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: loopback-fed instance with an 8-cycle timeout checked
// every cycle against a gate-count model, plus a timeout-disabled instance.
module tb_gate_sequencer;

  localparam int N = 5;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [31:0]  shift = '0;
  logic         force_sync = 1'b0;
  logic [N-1:0] force_val = '0;
  logic [N-1:0] loop8, loop0, sync8, sync0, en8, en0;
  logic         busy8, ready8, fault8, busy0, ready0, fault0;

  int vectors = 0;
  int miscompares = 0;

  // Model: number of gates on, mode, matched-dwell and consecutive-miss counts.
  int          m_mode;  // 0 idle, 1 ramp up, 2 on, 3 ramp down, 4 fault
  int          m_on;
  int          m_dwell;
  int          m_miss;
  logic [31:0] m_shift;
  logic        m_match;

  always #5 clk = ~clk;

  gate_sequencer #(.N_GATES(N), .CNT_W(32), .TIMEOUT(T)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .shift_i(shift), .gate_sync_i(sync8), .gate_en_o(en8),
    .busy_o(busy8), .ready_o(ready8), .fault_o(fault8)
  );

  gate_sequencer #(.N_GATES(N), .CNT_W(32), .TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .shift_i(shift), .gate_sync_i(sync0), .gate_en_o(en0),
    .busy_o(busy0), .ready_o(ready0), .fault_o(fault0)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop8 <= '0;
      loop0 <= '0;
    end else begin
      loop8 <= en8;
      loop0 <= en0;
    end
  end

  assign sync8 = force_sync ? force_val : loop8;
  assign sync0 = force_sync ? force_val : loop0;

  function automatic logic [N-1:0] pat(int k);
    return N'((1 << k) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_miss();
    if (m_miss == T - 1) begin
      m_mode = 4;
      m_on = 0;
      m_dwell = 0;
      m_miss = 0;
    end else begin
      m_miss++;
    end
  endtask

  task automatic model_ramp(input int dir);
    if (m_match) begin
      m_miss = 0;
      if (m_dwell == int'(m_shift)) begin
        m_on = m_on + dir;
        m_dwell = 0;
      end else begin
        m_dwell++;
      end
    end else begin
      model_miss();
    end
  endtask

  task automatic model_request(input int mode);
    m_mode = mode;
    m_shift = shift;
    m_dwell = 0;
    m_miss = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_on = 0;
      m_dwell = 0;
      m_miss = 0;
      m_shift = '0;
    end else begin
      m_match = (sync8 == pat(m_on));
      case (m_mode)
        0: if (start && !stop) model_request(1);
        1: begin
          if (stop) model_request(3);
          else if (m_on == N && m_match) begin
            m_mode = 2;
            m_dwell = 0;
            m_miss = 0;
          end else model_ramp(1);
        end
        2: begin
          if (stop) model_request(3);
          else if (m_match) m_miss = 0;
          else model_miss();
        end
        3: begin
          if (start && !stop) model_request(1);
          else if (m_on == 0 && m_match) begin
            m_mode = 0;
            m_dwell = 0;
            m_miss = 0;
          end else model_ramp(-1);
        end
        default: if (stop) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cycle", 32'({en8, busy8, ready8, fault8}),
          32'({pat(m_on), (m_mode == 1) || (m_mode == 3), m_mode == 2, m_mode == 4}));
    end
  end

  function automatic logic [7:0] obs(int sel);
    case (sel)
      0: return 8'(en8);
      1: return 8'(ready8);
      2: return 8'(busy8);
      default: return 8'(fault8);
    endcase
  endfunction

  task automatic wait_cond(input int sel, input logic [7:0] v, input int max, output int n);
    n = 0;
    while (obs(sel) !== v && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic [31:0] sh);
    start = s;
    stop = p;
    shift = sh;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int ones;
    logic [N-1:0] down_seq [4];
    logic [N-1:0] up_seq [4];
    up_seq = '{5'b00011, 5'b00111, 5'b01111, 5'b11111};
    down_seq = '{5'b00111, 5'b00011, 5'b00001, 5'b00000};

    @(negedge clk);
    chk("reset_outputs", 32'({en8, busy8, ready8, fault8}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp up through loopback, dwell 3.
    pulse(1'b1, 1'b0, 32'd3);
    chk("busy_on_start", 32'(busy8), 32'd1);
    wait_cond(0, 8'h01, 20, n);
    chk("first_step_latency", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      wait_cond(0, 8'(up_seq[i]), 20, n);
      chk("up_step_period", 32'(n), 32'd5);
    end
    wait_cond(1, 8'h01, 10, n);
    chk("ready_latency", 32'(n), 32'd2);

    // Ramp down from ON, dwell 0.
    pulse(1'b0, 1'b1, 32'd0);
    chk("stop_drops_ready", 32'({busy8, ready8}), 32'b10);
    wait_cond(0, 8'h0f, 10, n);
    chk("down_first_step", 32'(n), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_cond(0, 8'(down_seq[i]), 10, n);
      chk("down_step_period", 32'(n), 32'd2);
    end
    wait_cond(2, 8'h00, 10, n);
    chk("idle_after_down", 32'(n), 32'd2);

    // Stop mid ramp-up at 00111, dwell 1.
    pulse(1'b1, 1'b0, 32'd1);
    wait_cond(0, 8'h07, 40, n);
    chk("reach_00111", 32'(en8), 32'h07);
    pulse(1'b0, 1'b1, 32'd1);
    wait_cond(0, 8'h03, 10, n);
    chk("reverse_first", 32'(n), 32'd2);
    wait_cond(0, 8'h01, 10, n);
    chk("reverse_00001", 32'(n), 32'd3);
    wait_cond(0, 8'h00, 10, n);
    chk("reverse_00000", 32'(n), 32'd3);
    wait_cond(2, 8'h00, 10, n);
    chk("reverse_idle", 32'(n), 32'd2);

    // Simultaneous start/stop: no effect in IDLE, ramp-down from ON.
    pulse(1'b1, 1'b1, 32'd0);
    chk("both_in_idle", 32'({en8, busy8}), 32'h0);
    pulse(1'b1, 1'b0, 32'd0);
    wait_cond(1, 8'h01, 40, n);
    chk("ready_dwell0", 32'(ready8), 32'd1);
    pulse(1'b1, 1'b1, 32'd0);
    chk("both_in_on", 32'({en8, busy8, ready8}), 32'({5'b11111, 2'b10}));
    wait_cond(2, 8'h00, 40, n);

    // Sync stuck at zero: timeout fault.
    force_sync = 1'b1;
    force_val = '0;
    pulse(1'b1, 1'b0, 32'd0);
    n = 0;
    ones = 0;
    while (!fault8 && n < 30) begin
      if (en8 == 5'b00001) ones++;
      @(negedge clk);
      n++;
    end
    chk("fault_latency", 32'(n), 32'd9);
    chk("held_00001_cycles", 32'(ones), 32'd8);
    chk("fault_drops_gates", 32'(en8), 32'h0);
    chk("no_timeout_instance", 32'({en0, busy0, fault0}), 32'({5'b00001, 2'b10}));
    pulse(1'b1, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    chk("start_ignored_in_fault", 32'({en8, busy8, fault8}), 32'h1);
    pulse(1'b0, 1'b1, 32'd0);
    chk("stop_clears_fault", 32'({en8, busy8, ready8, fault8}), 32'h0);
    force_sync = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_timeout_idle", 32'({en0, busy0}), 32'h0);

    // Asynchronous reset mid-dwell at 00011.
    pulse(1'b1, 1'b0, 32'd3);
    wait_cond(0, 8'h03, 40, n);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({en8, busy8, ready8, fault8, en0, busy0}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(1'b1, 1'b0, 32'd3);
    wait_cond(0, 8'h01, 10, n);
    chk("restart_latency", 32'(n), 32'd4);
    chk("restart_from_00001", 32'(en8), 32'h01);
    wait_cond(1, 8'h01, 60, n);
    chk("restart_ready", 32'(ready8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_sequencer.md
# gate_sequencer

Parametrised power-gate sequencer. It ramps N gate enables on one at a time and off in reverse order, with a programmable dwell between steps. Each step waits for the gate-sync feedback to echo the current enable pattern, and a sync timeout drives a fault. It sits between the top-level control registers and the gate drivers, and serves as the generalised successor of the fixed 5-gate startup shifter.

## Interface
- N_GATES, 5, number of gate enables (≥2)
- CNT_W, 32, width of dwell and timeout counters
- TIMEOUT, 0, consecutive sync-mismatch cycles before fault; 0 disables the timeout
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle request to ramp up
- stop_i  in  1  single-cycle request to ramp down; also clears a fault
- shift_i  in  CNT_W  dwell value; sampled into shift_q on accepted start_i/stop_i
- gate_sync_i  in  N_GATES  gate status feedback
- gate_en_o  out  N_GATES  gate enables, registered
- busy_o  out  1  ramp in progress (RAMP_UP or RAMP_DOWN)
- ready_o  out  1  all gates on and confirmed (ON)
- fault_o  out  1  sync timeout latched (FAULT)

## Operation
- States: IDLE, RAMP_UP, ON, RAMP_DOWN, FAULT. All outputs derive from registered state and gate_en.
- "match" means gate_sync_i == gate_en.
- Step rule, applied in RAMP_UP and RAMP_DOWN:
  - match and cnt == shift_q: take a step, cnt <= 0, to_cnt <= 0.
  - match and cnt < shift_q: cnt <= cnt + 1, to_cnt <= 0.
  - mismatch: cnt holds, to_cnt <= to_cnt + 1.
- Up step: gate_en <= {gate_en[N-2:0], 1'b1}. Down step: gate_en <= {1'b0, gate_en[N-1:1]}, so the last gate enabled is the first disabled.
- IDLE: gate_en = 0.
  - start_i: go to RAMP_UP, latch shift_q, clear cnt and to_cnt.
  - stop_i: ignored.
- RAMP_UP:
  - gate_en all ones with match: go to ON; no dwell is applied to the final step.
  - stop_i: go to RAMP_DOWN from the current gate_en; latch shift_q, clear cnt.
  - start_i: ignored.
- ON: stop_i goes to RAMP_DOWN (latch shift_q, clear cnt). start_i is ignored.
- RAMP_DOWN:
  - gate_en == 0 with match: go to IDLE.
  - start_i: go to RAMP_UP from the current gate_en; latch shift_q, clear cnt.
- Timeout: when TIMEOUT ≠ 0, a mismatch while to_cnt == TIMEOUT-1 enters FAULT. On entry, gate_en <= 0 in the same edge and cnt/to_cnt are cleared.
  - The timeout also applies in ON: a mismatch in ON counts to_cnt, and a match clears it.
- FAULT: gate_en = 0 and fault_o = 1. stop_i goes to IDLE. start_i is ignored.
- start_i and stop_i in the same cycle: stop_i wins everywhere.
- Arithmetic: cnt and to_cnt are CNT_W bits, unsigned. Neither counter can wrap, because the compare fires first.
- shift_q = 0 gives one step per matched cycle.

## Timing
- Reset: state = IDLE; gate_en_o, busy_o, ready_o and fault_o are all 0; cnt, to_cnt and shift_q are 0.
- Reset asserted mid-ramp drops all enables asynchronously.
- Request latency: start_i/stop_i sampled at edge k change state and busy_o at edge k. The first gate change comes no earlier than edge k+1+shift_q.
- Step period = (shift_q + 1) matched cycles, plus any mismatch cycles. Mismatch cycles stall the step and are not counted in cnt.
- ready_o asserts on the edge after the match on all ones. It deasserts on the edge that accepts stop_i.
- fault_o asserts on the TIMEOUT-th consecutive mismatch edge. gate_en_o is 0 on that same edge.

## Test plan
- Loopback with 1-cycle delay (gate_sync_i = gate_en_o delayed by 1), N_GATES=5, shift_i=3, start_i pulse:
  - gate_en_o goes 00001, 00011, 00111, 01111, 11111, with 5 cycles per step (4 matched + 1 mismatch).
  - ready_o rises 2 cycles after gate_en_o reaches 11111.
  - busy_o is high throughout the ramp.
- From ON, stop_i with shift_i=0: gate_en_o goes 01111, 00111, 00011, 00001, 00000 every 2 cycles, then IDLE. busy_o falls and ready_o = 0.
- stop_i while gate_en_o = 00111 during RAMP_UP: the next steps are 00011, 00001, 00000; no further up-step occurs.
- start_i and stop_i in the same cycle from IDLE: no effect. Same pair from ON: enters RAMP_DOWN.
- TIMEOUT=8, gate_sync_i stuck at 0 after start_i with shift=0:
  - gate_en_o = 00001 persists for 8 mismatch cycles, then fault_o = 1 and gate_en_o = 00000.
  - start_i is then ignored; stop_i returns to IDLE with fault_o = 0.
- Async reset while gate_en_o = 00011 mid-dwell: all outputs go to 0 immediately. A fresh start_i then restarts from 00001.
